// File: rtl/exp_table_pingpong.sv
// Double-buffered exponent lookup table: one bank fills from the calculator
// write stream while the Monte-Carlo core reads the other; iSwap exchanges them.
module exp_table_pingpong #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iWrDone,
  input  logic              iSwap,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid,
  output logic              oRdReady,
  output logic              oFull,
  output logic              oWrBank,
  output logic [ADDR_W:0]   oWrCount,
  output logic              oOverrun,
  output logic              oSwapErr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Both banks live in one array; the bank index is the top address bit.
  logic [DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [0:0]        state;
  logic              wrAccept;

  assign wrAccept = (state == FILL) && iWrEn;
  assign oFull    = (state == FULL);

  always_ff @(posedge CLK) begin
    if (wrAccept) mem[{oWrBank, iWrAddr}] <= iWrData;
  end

  // Read bank is always the one not being written; a same-edge swap still
  // sees the old bank because oWrBank updates after this edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      oRdData  <= '0;
      oRdValid <= 1'b0;
    end else begin
      oRdValid <= iRdEn && oRdReady;
      if (iRdEn) oRdData <= mem[{~oWrBank, iRdAddr}];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= FILL;
      oWrBank  <= 1'b0;
      oWrCount <= '0;
      oRdReady <= 1'b0;
      oOverrun <= 1'b0;
      oSwapErr <= 1'b0;
    end else begin
      oOverrun <= (state == FULL) && iWrEn;
      oSwapErr <= (state == FILL) && iSwap;
      if (state == FILL) begin
        if (iWrEn && (oWrCount != CNT_MAX)) oWrCount <= oWrCount + 1'b1;
        if (iWrDone) state <= FULL;
      end else if (iSwap) begin
        state    <= FILL;
        oWrBank  <= ~oWrBank;
        oRdReady <= 1'b1;
        oWrCount <= '0;
      end
    end
  end
endmodule

// File: doc/exp_table_pingpong.md
# exp_table_pingpong

Double-buffered lookup table that sits between the exponent calculators (ExpMu/ExpSigma) and one Monte-Carlo core. It is the reader side of the calculators' time-multiplexed address/data write stream. It captures one complete table into the write bank while the core reads the previous table from the read bank, and swaps banks on a start pulse from the top-level controller. It replaces the bare `Switch`-driven bank select with explicit fill/valid handshakes and error flags.

## Interface
- `ADDR_W`, 9: table address width; depth = 2^ADDR_W (9 for ExpMu tables, 10 for ExpSigma tables).
- `DATA_W`, 18: entry width (unsigned fraction, passed through untouched).

- `CLK`  in  1  single clock, all logic on rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `iWrEn`  in  1  write strobe (the calculator busy/valid qualifier).
- `iWrAddr`  in  ADDR_W  write address.
- `iWrData`  in  DATA_W  write data.
- `iWrDone`  in  1  one-cycle pulse: the current table is complete.
- `iSwap`  in  1  one-cycle pulse: the core starts a new run; the filled bank becomes the read bank.
- `iRdEn`  in  1  read request.
- `iRdAddr`  in  ADDR_W  read address.
- `oRdData`  out  DATA_W  registered read data.
- `oRdValid`  out  1  `oRdData` is valid this cycle.
- `oRdReady`  out  1  the read bank holds a complete table.
- `oFull`  out  1  the write bank is complete and waiting for a swap.
- `oWrBank`  out  1  index of the bank currently being written.
- `oWrCount`  out  ADDR_W+1  writes accepted into the current fill.
- `oOverrun`  out  1  one-cycle pulse: a write was dropped because the bank was full.
- `oSwapErr`  out  1  one-cycle pulse: `iSwap` arrived while not full and was ignored.

## Operation
- Storage: two banks of 2^ADDR_W x DATA_W, implemented as inferred block RAM. One write port and one read port. Contents are not cleared by reset.
- Write-side FSM has two states: FILL and FULL.
  - In FILL, `iWrEn` writes `iWrData` to bank `oWrBank` at `iWrAddr` and increments `oWrCount` (saturating at 2^ADDR_W).
  - `iWrDone` in FILL moves to FULL.
  - In FULL, `iWrEn` is dropped and pulses `oOverrun`.
  - `iWrDone` in FULL is ignored.
- Swap:
  - `iSwap` in FULL: toggle `oWrBank`, set `oRdReady`=1, clear `oWrCount`, return to FILL.
  - `iSwap` in FILL: no state change; pulse `oSwapErr`.
- Read bank is always ~`oWrBank`.
  - `iRdEn` reads the read bank at `iRdAddr`.
  - Reads issued while `oRdReady`=0 still return RAM contents, but `oRdValid` stays 0.
- Duplicate or out-of-order write addresses are allowed. `oWrCount` counts strobes, not unique addresses.
- `iWrDone` with `oWrCount` below 2^ADDR_W is legal; the block still goes FULL. Checking the count is the controller's job.

## Timing
- Reset values: `oRdData`=0, `oRdValid`=0, `oRdReady`=0, `oFull`=0, `oWrBank`=0, `oWrCount`=0, `oOverrun`=0, `oSwapErr`=0. FSM starts in FILL.
- Reset asserted mid-fill or mid-read: everything returns to reset values immediately. Any partial table is abandoned, and `oRdValid` for an in-flight read is suppressed.
- Write latency: data written at edge N is readable by a read issued at edge N+1 (relevant after a swap).
- Read latency: 1 cycle. `iRdEn` sampled at edge N gives `oRdData` and `oRdValid` after edge N+1. `oRdValid` = registered (`iRdEn` & `oRdReady`).
- `oFull` rises the cycle after `iWrDone` and falls the cycle after an accepted `iSwap`. `oOverrun` and `oSwapErr` are high for exactly one cycle.
- Same-edge `iWrEn` and `iWrDone` in FILL: the write is accepted, then the FSM goes FULL.
- Same-edge `iWrDone` and `iSwap` in FILL: the swap is rejected with `oSwapErr`; the FSM goes FULL.
- Same-edge `iSwap` and `iWrEn` in FULL: the write is dropped with `oOverrun`; the swap takes effect.
- Same-edge `iSwap` and `iRdEn`: the read uses the pre-swap read bank. The next read uses the new bank.
- Back-to-back `iSwap`: the second pulse finds FILL and raises `oSwapErr`.

## Test plan
- Reset, then fill bank 0 with addr a -> data a+1 for all 512 entries, pulse `iWrDone`, pulse `iSwap`. Required: `oWrBank`=1, `oRdReady`=1, and reading addr 37 gives 38 one cycle later with `oRdValid`=1.
- Read with `oRdReady`=0 -> `oRdValid` stays 0.
- While reading bank 0, fill bank 1 with data 0x3FFFF. Required: reads still return the original a+1 values until the next `iSwap`, then return 0x3FFFF.
- After `iWrDone`, write addr 5 = 0x12345. Required: one `oOverrun` pulse, `oWrCount` unchanged, and addr 5 reads its old value after the swap.
- `iSwap` with no prior `iWrDone` -> one `oSwapErr` pulse, `oWrBank` unchanged. `iWrDone` and `iSwap` on the same edge -> `oSwapErr` and `oFull`=1.
- Assert `RSTn`=0 at write 200 of a fill -> all outputs return to reset values asynchronously. After release, `oWrCount`=0 and `oRdReady`=0.
